uart_rx_checked: RTL
====================

# uart_rx_checked

Hardened UART receiver that terminates the serial line driven by `uart_tx`. It deserializes 8N1 frames into bytes and adds input synchronization, start-bit glitch rejection, framing-error reporting and an asynchronous active-low reset. It sits between the board RX pin and byte-level consumers such as command parsers and FIFOs. It is the production-grade counterpart to the transmitter; the bench loops `uart_tx` into it.

## Interface
- `CLKS_PER_BIT`, 217: clocks per bit (25 MHz / 115200). Legal values are ≥ 4.
- `i_Clock`  in  1  system clock; all state updates on the rising edge.
- `i_Rst_L`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_RX_Serial`  in  1  raw serial line; idle high; asynchronous to `i_Clock`.
- `o_RX_DV`  out  1  one-cycle pulse when `o_RX_Byte` is updated with a valid frame.
- `o_RX_Byte`  out  8  last correctly received byte; holds between frames.
- `o_Frame_Err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `o_RX_Busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer.** Two flops, both reset to 1, produce `rx_sync`. A third flop holds `rx_prev` for edge detection. All decisions use `rx_sync` only.
- **Counters.**
  - Bit-time counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..CLKS_PER_BIT-1 and never wraps past the terminal value.
  - 3-bit `bit_idx` counts the data bits.
  - `HALF = (CLKS_PER_BIT-1)/2` (integer division; 108 for 217).
- **FSM states and transitions:**
  - IDLE: when `rx_prev`=1 and `rx_sync`=0 (falling edge), go to START with `cnt`=0. No other exit.
  - START: increment `cnt`. When `cnt`==HALF, sample `rx_sync`. If 0, go to DATA with `cnt`=0 and `bit_idx`=0. If 1, treat as a glitch and return to IDLE with no output pulse.
  - DATA: increment `cnt`. When `cnt`==CLKS_PER_BIT-1:
    - shift `rx_sync` into shift-register position `bit_idx` (LSB first);
    - reset `cnt` to 0;
    - after `bit_idx`==7, go to STOP; otherwise increment `bit_idx`.
  - STOP: when `cnt`==CLKS_PER_BIT-1, sample `rx_sync`.
    - If 1: load `o_RX_Byte` from the shift register, pulse `o_RX_DV`, go to IDLE.
    - If 0: pulse `o_Frame_Err`, leave `o_RX_Byte` unchanged, go to BREAK.
  - BREAK: stay until `rx_sync`=1, then go to IDLE. This prevents a held-low line (break) from being decoded as 0x00 frames.
- `o_RX_DV` and `o_Frame_Err` are never high in the same cycle.
- Valid-stop handling returns to IDLE at mid-stop-bit, so back-to-back frames with zero idle time are received.
- **Reset.** Asserting `i_Rst_L` mid-frame forces IDLE immediately and clears all outputs; the partial frame is discarded. After release, correct reception is guaranteed for any frame whose start edge follows ≥ 1 bit time of idle-high line.

## Timing
- **Reset values:**
  - `o_RX_DV`=0, `o_Frame_Err`=0, `o_RX_Busy`=0, `o_RX_Byte`=8'h00;
  - synchronizer flops and `rx_prev`=1;
  - FSM=IDLE, `cnt`=0, `bit_idx`=0.
- Synchronizer latency: 2 clocks from a line change to `rx_sync`.
- Let t0 be the IDLE cycle that detects the falling edge.
  - Start-bit check occurs at t0+1+HALF.
  - Data bit k (k=0..7) is sampled at t0+1+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at t0+1+HALF+9·CLKS_PER_BIT (t0+2062 for 217).
- `o_RX_DV` or `o_Frame_Err` is high during the one clock that follows the stop-sample edge. `o_RX_Byte` is valid in that same cycle.
- `o_RX_Busy` rises the clock after t0 and falls in the same cycle `o_RX_DV` rises. On the glitch path it falls the cycle after the rejected start check.
- Throughput: one byte per 10 bit times; no per-byte dead cycles.

## Test plan
- **Nominal frame.** `uart_tx` (CLKS_PER_BIT=217) sends 0x3F → exactly one `o_RX_DV` pulse, `o_RX_Byte`=0x3F, `o_Frame_Err` never high, DV at t0+2063 ± 0.
- **Back-to-back.** Frames 0x00, 0xFF, 0xA5 with zero idle between them → three DV pulses, exactly 2170 clocks apart, bytes in order.
- **Start glitch.** Line held low for 50 clocks, then high → no DV, no error; `o_RX_Busy` high for ≤ 110 clocks, then 0. A following 0x5A frame is received correctly.
- **Framing error.** After a good 0x3F, send 0xC3 with stop bit low, then hold the line low for 3 bit times → one `o_Frame_Err` pulse, no DV, `o_RX_Byte` stays 0x3F, FSM stays in BREAK until the line goes high. Next frame 0x81 is received.
- **Reset mid-frame.** Assert `i_Rst_L`=0 during data bit 4 of 0x77 → all outputs at reset values in the same cycle, no DV for 0x77. Release, idle 1 bit time, send 0x12 → DV with 0x12.
- **Minimum parameter.** CLKS_PER_BIT=4, random 256-byte stream from `uart_tx` → every byte matches, zero framing errors.

Source files
------------

// File: rtl/uart_rx_checked_if.sv
// Byte-side outputs of the hardened UART receiver.
// master drives them, slave consumes them.
interface uart_rx_checked_if;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_Frame_Err;
  logic       o_RX_Busy;

  modport master (
    output o_RX_DV,
    output o_RX_Byte,
    output o_Frame_Err,
    output o_RX_Busy
  );

  modport slave (
    input o_RX_DV,
    input o_RX_Byte,
    input o_Frame_Err,
    input o_RX_Busy
  );
endinterface

// File: rtl/uart_rx_checked.sv
// Hardened 8N1 UART receiver: synchronized input, start-glitch
// rejection, framing-error pulse and break hold-off.
module uart_rx_checked #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_RX_Serial,
  uart_rx_checked_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic          rx_dv;
  logic          frame_err;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= i_RX_Serial;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            // a start bit that is high again by mid-bit was noise
            if (!rx_sync) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              rx_byte <= shreg;
              rx_dv   <= 1'b1;
              state   <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // wait out a held-low line instead of decoding 0x00 frames
          if (rx_sync) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_bus.o_RX_DV     = rx_dv;
  assign rx_bus.o_RX_Byte   = rx_byte;
  assign rx_bus.o_Frame_Err = frame_err;
  assign rx_bus.o_RX_Busy   = (state != S_IDLE);

endmodule
